// File: rtl/servant_irq_sched.sv
// Wishbone-slave external-interrupt scheduler for servant builds.
// Raises o_ext_irq a programmed number of cycles after arming, with optional
// periodic reload. The request clears on a write-1-to-clear or on mret.
// It also counts interrupts, flags overruns, and can record how long the
// CPU took to accept an interrupt.
// Ports:
//   wb_clk, wb_rst_n       clock, asynchronous active-low reset
//   i_wb_adr/dat/we/cyc/stb Wishbone slave request (word address 0..3)
//   o_wb_rdt, o_wb_ack     Wishbone read data / acknowledge
//   i_new_irq, i_mret      CPU accepted-interrupt and mret pulses
//   o_ext_irq              level interrupt request to the CPU
// Registers: 0 CTRL{MRET_CLR,RELOAD,EN}, 1 CMP, 2 STATUS{COUNT[15:8],OVR,PEND}, 3 LAT
// Optional macro SERVANT_IRQ_SCHED_LAT_EN: enables the acceptance-latency counter.
// Without it, LAT reads 0.
module servant_irq_sched #(
    parameter int unsigned CMP_RESET  = 3000,
    parameter bit          AUTO_START = 1'b0,
    parameter int unsigned CNT_SAT    = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic        i_new_irq,
    input  logic        i_mret,
    output logic        o_ext_irq
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [DW-1:0] CMP_RST = DW'(CMP_RESET);
    localparam logic [DW-1:0] CNT_ARM = (CMP_RESET == 0) ? DW'(1) : DW'(CMP_RESET);
    localparam logic [DW-1:0] CNT_RST = AUTO_START ? CNT_ARM : '0;
    localparam logic [CW-1:0] SAT     = CW'(CNT_SAT);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
    localparam state_t RST_STATE = AUTO_START ? S_RUN : S_IDLE;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_cnt, r_cmp, r_rdt;
    logic [CW-1:0]   r_count;
    logic            r_en, r_reload, r_mret_clr, r_pend, r_ovr, r_ack;

    logic            w_req, w_wr, w_ctrl_wr, w_cmp_wr, w_stat_wr;
    logic            w_dis, w_arm, w_run, w_expire, w_pend_clr, w_pend_nxt;
    logic [DW-1:0]   w_cmp_eff, w_arm_val, w_lat_val, w_rd_mux;

    // Bus decode: new request when idle; writes commit at the end of the ack cycle.
    always_comb begin
        w_req     = i_wb_cyc & i_wb_stb & ~r_ack;
        w_wr      = r_ack & i_wb_cyc & i_wb_stb & i_wb_we;
        w_ctrl_wr = w_wr && (i_wb_adr == 2'd0);
        w_cmp_wr  = w_wr && (i_wb_adr == 2'd1);
        w_stat_wr = w_wr && (i_wb_adr == 2'd2);
        w_dis     = w_ctrl_wr && !i_wb_dat[0];
        // Arm on CMP write with EN set (also re-arms in RUN), or on EN 0->1.
        w_arm     = (w_cmp_wr && r_en) || (w_ctrl_wr && i_wb_dat[0] && !r_en);
        // A programmed delay of 0 behaves as 1.
        w_cmp_eff = (r_cmp == '0) ? DW'(1) : r_cmp;
        w_arm_val = w_cmp_wr ? ((i_wb_dat == '0) ? DW'(1) : i_wb_dat) : w_cmp_eff;
    end

    // FSM state register
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) r_state <= RST_STATE;
        else           r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_arm) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_dis)                      w_state_nxt = S_IDLE;
                else if (w_arm)                 w_state_nxt = S_RUN;
                else if (w_expire && !r_reload) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: expiry on the cnt==1 cycle unless EN is being cleared.
    always_comb begin
        w_run    = (r_state == S_RUN);
        w_expire = w_run && (r_cnt == DW'(1)) && !w_dis;
    end

    // Pending flag: disable beats everything, expiry beats a same-cycle clear.
    always_comb begin
        w_pend_clr = (w_stat_wr && i_wb_dat[0]) || (i_mret && r_mret_clr && r_pend);
        w_pend_nxt = r_pend;
        if (w_dis)           w_pend_nxt = 1'b0;
        else if (w_expire)   w_pend_nxt = 1'b1;
        else if (w_pend_clr) w_pend_nxt = 1'b0;
    end

    // Control, countdown and status registers
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_en       <= AUTO_START;
            r_reload   <= 1'b0;
            r_mret_clr <= 1'b0;
            r_cmp      <= CMP_RST;
            r_cnt      <= CNT_RST;
            r_pend     <= 1'b0;
            r_ovr      <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en       <= i_wb_dat[0];
                r_reload   <= i_wb_dat[1];
                r_mret_clr <= i_wb_dat[2];
            end
            if (w_cmp_wr) r_cmp <= i_wb_dat;

            if (w_arm)                 r_cnt <= w_arm_val;
            else if (w_expire)         r_cnt <= r_reload ? w_cmp_eff : '0;
            else if (w_run && !w_dis)  r_cnt <= r_cnt - DW'(1);

            r_pend <= w_pend_nxt;

            if (w_expire && r_pend && !w_pend_clr)  r_ovr <= 1'b1;
            else if (w_stat_wr && i_wb_dat[1])      r_ovr <= 1'b0;

            if (w_stat_wr)
                r_count <= (w_expire && !r_pend) ? CW'(1) : '0;
            else if (w_expire && !r_pend && (r_count != SAT))
                r_count <= r_count + CW'(1);
        end
    end

`ifdef SERVANT_IRQ_SCHED_LAT_EN
    logic [DW-1:0] r_lat, r_lat_cnt, w_lat_inc;
    logic          r_lat_done;

    assign w_lat_inc = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + DW'(1);

    // Latency: restart on PEND rise, capture on the first acceptance only.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_lat      <= '0;
            r_lat_cnt  <= '0;
            r_lat_done <= 1'b0;
        end else if (w_pend_nxt && !r_pend) begin
            r_lat_cnt  <= '0;
            r_lat_done <= 1'b0;
        end else if (r_pend && !r_lat_done) begin
            if (i_new_irq) begin
                r_lat      <= w_lat_inc;
                r_lat_done <= 1'b1;
            end else begin
                r_lat_cnt  <= w_lat_inc;
            end
        end
    end

    assign w_lat_val = r_lat;
`else
    logic w_unused_new_irq;
    assign w_unused_new_irq = i_new_irq;
    assign w_lat_val        = '0;
`endif

    // Read mux
    always_comb begin
        w_rd_mux = '0;
        case (i_wb_adr)
            2'd0: w_rd_mux = {29'b0, r_mret_clr, r_reload, r_en};
            2'd1: w_rd_mux = r_cmp;
            2'd2: w_rd_mux = {16'b0, r_count, 6'b0, r_ovr, r_pend};
            2'd3: w_rd_mux = w_lat_val;
            default: w_rd_mux = '0;
        endcase
    end

    // Single-cycle ack; read data captured with it and held afterwards.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack <= 1'b0;
            r_rdt <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_rdt <= w_rd_mux;
        end
    end

    assign o_wb_ack  = r_ack;
    assign o_wb_rdt  = r_rdt;
    assign o_ext_irq = r_pend;

endmodule
